// File: rtl/lse_reduce_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : lse_reduce_ctrl
// Purpose  : Reduces a frame of N log-domain values to ln(sum(exp(x_i))) by
//            time-sharing one external fixed-latency log-sum-exp unit.
//            Incoming values and returning partial sums form one arrival
//            stream. Consecutive arrivals are paired and issued to the unit.
//            When the frame is complete and nothing is in flight, the single
//            remaining value is the frame result.
// Ports    : clk, rst (async, active-high)
//            in_valid/in_ready/in_data/in_last   - producer stream
//            out_valid/out_data                  - one pulse per frame
//            lse_in_valid/lse_a/lse_b            - issue to shared unit
//            lse_out_valid/lse_c                 - result from shared unit
// Revision : 1.0 - initial release
// ============================================================================
module lse_reduce_ctrl #(
    parameter int BITS      = 16,
    parameter     PRECISION = "HALF",
    parameter int LATENCY   = 80
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [BITS-1:0] in_data,
    input  logic            in_last,
    output logic            out_valid,
    output logic [BITS-1:0] out_data,
    output logic            lse_in_valid,
    output logic [BITS-1:0] lse_a,
    output logic [BITS-1:0] lse_b,
    input  logic            lse_out_valid,
    input  logic [BITS-1:0] lse_c
);

    localparam int c_INF_W   = $clog2(LATENCY + 2);
    localparam int c_FLUSH_W = $clog2(LATENCY + 1);

    localparam logic [c_INF_W-1:0]   c_INF_ONE    = c_INF_W'(1);
    localparam logic [c_FLUSH_W-1:0] c_FLUSH_ONE  = c_FLUSH_W'(1);
    localparam logic [c_FLUSH_W-1:0] c_FLUSH_LAST = c_FLUSH_W'(LATENCY - 1);

    // The format is only carried for consistency with the attached unit;
    // catch an obviously mismatched width at elaboration.
    generate
        if ((PRECISION == "HALF") && (BITS != 16)) begin : g_bad_half_width
            $error("lse_reduce_ctrl: HALF precision requires BITS == 16");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_FLUSH  = 2'd0,
        S_ACCEPT = 2'd1,
        S_DRAIN  = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_next;
    logic [c_FLUSH_W-1:0] r_flush_cnt;
    logic [BITS-1:0]      r_hold;
    logic                 r_hold_v;
    logic [c_INF_W-1:0]   r_inflight;
    logic                 r_out_valid;
    logic [BITS-1:0]      r_out_data;
    logic                 r_issue;
    logic [BITS-1:0]      r_lse_a;
    logic [BITS-1:0]      r_lse_b;

    logic                 w_ready;
    logic                 w_ret;
    logic                 w_acc;
    logic                 w_v_valid;
    logic [BITS-1:0]      w_v_data;
    logic                 w_issue;
    logic                 w_emit;

    // ------------------------------------------------------------------------
    // Next-state and per-cycle decisions
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_ready      = 1'b0;
        w_ret        = 1'b0;
        w_acc        = 1'b0;
        w_v_valid    = 1'b0;
        w_v_data     = in_data;
        w_issue      = 1'b0;
        w_emit       = 1'b0;

        // A returning result always wins over the producer.
        w_ready   = (r_state == S_ACCEPT) && !lse_out_valid;
        // Results are discarded during flush, and a result with nothing in
        // flight is a protocol error that is dropped.
        w_ret     = lse_out_valid && (r_state != S_FLUSH) && (r_inflight != '0);
        w_acc     = in_valid && w_ready;
        w_v_valid = w_ret || w_acc;
        w_v_data  = w_ret ? lse_c : in_data;
        w_issue   = w_v_valid && r_hold_v;
        w_emit    = (r_state == S_DRAIN) && (r_inflight == '0) && r_hold_v
                    && !lse_out_valid;

        case (r_state)
            S_FLUSH: begin
                if (r_flush_cnt == c_FLUSH_LAST) begin
                    w_state_next = S_ACCEPT;
                end
            end
            S_ACCEPT: begin
                if (w_acc && in_last) begin
                    w_state_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (w_emit) begin
                    w_state_next = S_ACCEPT;
                end
            end
            default: begin
                w_state_next = S_FLUSH;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_FLUSH;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------------
    // Datapath: flush timer, pairing register, in-flight count, outputs
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_flush_cnt <= '0;
            r_hold      <= '0;
            r_hold_v    <= 1'b0;
            r_inflight  <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_issue     <= 1'b0;
            r_lse_a     <= '0;
            r_lse_b     <= '0;
        end else begin
            if (r_state == S_FLUSH) begin
                r_flush_cnt <= r_flush_cnt + c_FLUSH_ONE;
            end

            // Each new value either parks in hold or pairs with it.
            r_issue <= w_issue;
            if (w_v_valid) begin
                if (!r_hold_v) begin
                    r_hold   <= w_v_data;
                    r_hold_v <= 1'b1;
                end else begin
                    r_lse_a  <= r_hold;
                    r_lse_b  <= w_v_data;
                    r_hold_v <= 1'b0;
                end
            end else if (w_emit) begin
                r_hold_v <= 1'b0;
            end

            // Issue and return in the same cycle cancel out.
            case ({w_issue, w_ret})
                2'b10:   r_inflight <= r_inflight + c_INF_ONE;
                2'b01:   r_inflight <= r_inflight - c_INF_ONE;
                default: r_inflight <= r_inflight;
            endcase

            r_out_valid <= w_emit;
            if (w_emit) begin
                r_out_data <= r_hold;
            end
        end
    end

    assign in_ready     = w_ready;
    assign out_valid    = r_out_valid;
    assign out_data     = r_out_data;
    assign lse_in_valid = r_issue;
    assign lse_a        = r_lse_a;
    assign lse_b        = r_lse_b;

endmodule
`default_nettype wire
